// File: rtl/spmv_dot_lanes_if.sv
// AXI-Stream style valid/ready channel used by the SpMV dot-product lanes.
// tuser is carried on every channel; input channels leave it unused.
interface spmv_dot_lanes_if #(
    parameter int W = 32,
    parameter int U = 1
) ();
    logic [W-1:0] tdata;
    logic [U-1:0] tuser;
    logic         tvalid;
    logic         tready;

    modport master (
        output tdata,
        output tuser,
        output tvalid,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tuser,
        input  tvalid,
        output tready
    );
endinterface

// File: rtl/spmv_dot_lanes.sv
// Multi-lane signed fixed-point SpMV row dot product with saturating
// accumulation, zero-length rows and a first-word-fall-through result FIFO.
module spmv_dot_lanes #(
    parameter int LANES     = 4,
    parameter int DATA_W    = 32,
    parameter int FRAC_W    = 16,
    parameter int ACC_W     = 64,
    parameter int CNT_W     = 32,
    parameter int OUT_DEPTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    spmv_dot_lanes_if.slave  S_AXIS_A,
    spmv_dot_lanes_if.slave  S_AXIS_B,
    spmv_dot_lanes_if.slave  S_AXIS_TIMES,
    spmv_dot_lanes_if.master M_AXIS_OUT,
    output logic [31:0]      rows_done
);
    localparam int PW    = 2 * DATA_W;
    localparam int LG    = $clog2(LANES);
    // Sum width never narrower than the raw tree, so clipping is exact
    localparam int SW    = (ACC_W > PW + LG) ? ACC_W : PW + LG;
    localparam int PTR_W = $clog2(OUT_DEPTH);
    localparam int EW    = ACC_W + 2;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             first_q, first_d;

    logic en, stall, push, pop, full, empty;
    logic times_rdy, a_rdy, b_rdy;
    logic in_valid, in_first, in_last, in_zero;
    logic [LANES-1:0] in_mask;

    logic signed [DATA_W-1:0] a_l  [LANES];
    logic signed [DATA_W-1:0] b_l  [LANES];
    logic signed [PW-1:0]     full_p [LANES];
    logic signed [PW-1:0]     prod [LANES];

    logic                 s1_v_q, s1_first_q, s1_last_q, s1_zero_q;
    logic signed [PW-1:0] s1_p_q [LANES];
    logic signed [SW-1:0] sum_c;
    logic                 s2_v_q, s2_first_q, s2_last_q, s2_zero_q;
    logic signed [SW-1:0] s2_sum_q;

    logic signed [ACC_W-1:0] acc_q, base, nxt;
    logic                    sat_q, sat_now, clip;
    logic signed [SW:0]      ext;
    logic [SW-ACC_W+1:0]     top;

    logic [EW-1:0]    mem [OUT_DEPTH];
    logic [PTR_W:0]   wr_q, rd_q;
    logic [EW-1:0]    head;
    logic [31:0]      rows_q;

    assign pop   = ~empty & M_AXIS_OUT.tready;
    assign stall = s2_v_q & s2_last_q & full & ~pop;
    assign en    = ~stall;
    assign push  = en & s2_v_q & s2_last_q;

    always_comb begin
        state_d   = state_q;
        rem_d     = rem_q;
        first_d   = first_q;
        times_rdy = 1'b0;
        a_rdy     = 1'b0;
        b_rdy     = 1'b0;
        in_valid  = 1'b0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        in_zero   = 1'b0;
        in_mask   = '0;
        unique case (state_q)
            IDLE: begin
                times_rdy = en & ~rst;
                if (times_rdy & S_AXIS_TIMES.tvalid) begin
                    if (S_AXIS_TIMES.tdata == '0) begin
                        in_valid = 1'b1;
                        in_first = 1'b1;
                        in_last  = 1'b1;
                        in_zero  = 1'b1;
                    end else begin
                        rem_d   = S_AXIS_TIMES.tdata;
                        first_d = 1'b1;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                a_rdy = en & ~rst & S_AXIS_B.tvalid;
                b_rdy = en & ~rst & S_AXIS_A.tvalid;
                if (a_rdy & S_AXIS_A.tvalid) begin
                    in_valid = 1'b1;
                    in_first = first_q;
                    in_last  = rem_q <= CNT_W'(LANES);
                    first_d  = 1'b0;
                    for (int i = 0; i < LANES; i++)
                        in_mask[i] = CNT_W'(i) < rem_q;
                    if (in_last) begin
                        rem_d   = '0;
                        state_d = IDLE;
                    end else begin
                        rem_d = rem_q - CNT_W'(LANES);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            a_l[i]    = S_AXIS_A.tdata[i*DATA_W +: DATA_W];
            b_l[i]    = S_AXIS_B.tdata[i*DATA_W +: DATA_W];
            full_p[i] = PW'(a_l[i]) * PW'(b_l[i]);
            prod[i]   = in_mask[i] ? (full_p[i] >>> FRAC_W) : '0;
        end
    end

    always_comb begin
        sum_c = '0;
        for (int i = 0; i < LANES; i++)
            sum_c = sum_c + SW'(s1_p_q[i]);
    end

    // Accumulate one bit wider than the sum, then clip back to ACC_W
    always_comb begin
        base = acc_q;
        if (s2_first_q)
            base = '0;
        ext  = (SW+1)'(base) + (SW+1)'(s2_sum_q);
        top  = ext[SW:ACC_W-1];
        clip = ~(&top) & (|top);
        if (!clip)
            nxt = ext[ACC_W-1:0];
        else if (ext[SW])
            nxt = {1'b1, {(ACC_W-1){1'b0}}};
        else
            nxt = {1'b0, {(ACC_W-1){1'b1}}};
        sat_now = (s2_first_q ? 1'b0 : sat_q) | clip;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            first_q    <= 1'b0;
            s1_v_q     <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_zero_q  <= 1'b0;
            s2_v_q     <= 1'b0;
            s2_first_q <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_zero_q  <= 1'b0;
            s2_sum_q   <= '0;
            for (int i = 0; i < LANES; i++)
                s1_p_q[i] <= '0;
        end else if (en) begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            first_q    <= first_d;
            s1_v_q     <= in_valid;
            s1_first_q <= in_first;
            s1_last_q  <= in_last;
            s1_zero_q  <= in_zero;
            for (int i = 0; i < LANES; i++)
                s1_p_q[i] <= prod[i];
            s2_v_q     <= s1_v_q;
            s2_first_q <= s1_first_q;
            s2_last_q  <= s1_last_q;
            s2_zero_q  <= s1_zero_q;
            s2_sum_q   <= sum_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q  <= '0;
            sat_q  <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            rows_q <= '0;
        end else begin
            if (en & s2_v_q) begin
                acc_q <= s2_last_q ? '0 : nxt;
                sat_q <= s2_last_q ? 1'b0 : sat_now;
            end
            if (push) begin
                wr_q   <= wr_q + 1'b1;
                rows_q <= rows_q + 32'd1;
            end
            if (pop)
                rd_q <= rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_q[PTR_W-1:0]] <= {s2_zero_q, sat_now, nxt};
    end

    assign empty = wr_q == rd_q;
    assign full  = wr_q == {~rd_q[PTR_W], rd_q[PTR_W-1:0]};
    assign head  = empty ? '0 : mem[rd_q[PTR_W-1:0]];

    assign M_AXIS_OUT.tvalid  = ~empty;
    assign M_AXIS_OUT.tdata   = head[ACC_W-1:0];
    assign M_AXIS_OUT.tuser   = head[EW-1:ACC_W];
    assign S_AXIS_A.tready    = a_rdy;
    assign S_AXIS_B.tready    = b_rdy;
    assign S_AXIS_TIMES.tready = times_rdy;
    assign rows_done          = rows_q;

    logic unused_ok;
    assign unused_ok = ^{S_AXIS_A.tuser, S_AXIS_B.tuser,
                         S_AXIS_TIMES.tuser};
endmodule

// File: doc/spmv_dot_lanes.md
Name: spmv_dot_lanes

Overview:
- Parametrised successor to the single-lane SpMV dot-product kernel: consumes LANES signed fixed-point A×B products per beat.
- Reduces each beat with an adder tree and accumulates it per row, using row lengths taken from a TIMES stream.
- Emits one saturated row result per TIMES descriptor through an internal FWFT output FIFO.
- Sits between the matrix/vector fetch streams and the result writer in the SpMV calc kernel. Adds zero-length rows, partial-beat masking, saturation and overflow flags.

Parameters:
LANES, 4, products per beat; power of two, 1..16
DATA_W, 32, signed operand width
FRAC_W, 16, fractional bits of operands and result
ACC_W, 64, signed accumulator/result width; must be >= 2*DATA_W-FRAC_W+log2(LANES)
CNT_W, 32, row element-count width
OUT_DEPTH, 16, output FIFO entries; power of two, >= 4

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
S_AXIS_A_tdata  in  LANES*DATA_W  matrix values; lane i at bits [i*DATA_W +: DATA_W]
S_AXIS_A_tvalid  in  1  A valid
S_AXIS_A_tready  out  1  A ready
S_AXIS_B_tdata  in  LANES*DATA_W  gathered vector values, same lane layout
S_AXIS_B_tvalid  in  1  B valid
S_AXIS_B_tready  out  1  B ready
S_AXIS_TIMES_tdata  in  CNT_W  element count of next row (unsigned)
S_AXIS_TIMES_tvalid  in  1  descriptor valid
S_AXIS_TIMES_tready  out  1  descriptor ready
M_AXIS_OUT_tdata  out  ACC_W  row dot product, signed, FRAC_W fractional bits
M_AXIS_OUT_tuser  out  2  [0] row saturated, [1] zero-length row
M_AXIS_OUT_tvalid  out  1  result valid
M_AXIS_OUT_tready  in  1  result ready
rows_done  out  32  count of results pushed into FIFO; wraps at 2^32

Behaviour:
- Reset: all tready 0, M_AXIS_OUT_tvalid 0, tdata/tuser 0, rows_done 0. FSM goes to IDLE, pipeline valids cleared, accumulator 0, FIFO emptied.
- Reset mid-row discards the partial row and all queued results.
- Stall: en = ~(s3_valid & s3_last & fifo_full). All pipeline registers hold when en=0.
- FSM IDLE:
  - TIMES_tready = en.
  - On a TIMES handshake with count=0, inject a token (valid, first, last, zero, data 0) into stage 1 and stay in IDLE.
  - On a handshake with count>0, load rem=count and go to RUN.
- FSM RUN:
  - A_tready = en & B_tvalid; B_tready = en & A_tvalid. A beat is consumed only when both handshake in the same cycle.
  - Per beat, lanes with index >= rem are zeroed (partial final beat).
  - The first beat of a row carries first=1.
  - rem -= LANES, saturating at 0. When the pre-decrement rem <= LANES the beat carries last=1 and FSM returns to IDLE.
  - TIMES_tready = 0 in RUN.
- Stage 1 (reg): per lane, full 2*DATA_W signed product, arithmetic right shift by FRAC_W (floor). Masked lanes are 0.
- Stage 2 (reg): combinational adder tree over LANES lanes, sign-extended to ACC_W.
- Stage 3 (acc):
  - next = (first ? 0 : acc) + sum, computed at ACC_W+1 bits and saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - A sticky sat flag is set on clipping and cleared at first.
  - On last: push {zero, sat|clip, next} into the FIFO, increment rows_done, clear acc and sat.
- Latency: last beat handshake in cycle N gives M_AXIS_OUT_tvalid in cycle N+3, with FIFO empty and no stall. A zero-length descriptor also takes 3 cycles.
- Ordering: results leave in descriptor order, zero-length rows included, since tokens share the pipeline.
- FIFO full with stage 3 holding last: whole pipeline and all input readies stall, no data loss. Simultaneous FIFO pop and push when full is allowed, and en stays 1 that cycle.
- Output obeys AXIS rules: tdata/tuser stable while tvalid & ~tready.

Test Plan:
1. LANES=4, FRAC_W=16: TIMES=8; A lanes 0x00010000 (1.0), B 0x00020000 (2.0), 2 beats -> tdata 0x100000 (16.0), tuser 0, valid exactly 3 cycles after the 2nd beat.
2. TIMES=5; beat 2 lanes 1..3 hold 0x7FFFFFFF garbage; all valid elements 1.0×1.0 -> tdata 0x50000, tuser 0.
3. TIMES stream 2,0,3 with all products 1.0 -> outputs 0x20000/tuser 0, 0/tuser 2'b10, 0x30000/tuser 0, in that order; rows_done=3.
4. M_AXIS_OUT_tready=0; 20 rows with TIMES=1 -> 16 results held, A/B/TIMES readies drop. Release tready -> all 20 outputs delivered in order, no loss or duplication.
5. ACC_W=34 override: 8 beats of 4 lanes 0x7FFF0000×0x7FFF0000 -> tdata 0x1FFFFFFFF, tuser[0]=1. Next row TIMES=1 of 1.0×1.0 -> 0x10000, tuser[0]=0.
6. rst=1 for 1 cycle after 1 of 3 beats of a row -> no output. A new TIMES=4 row of 1.0×3.0 -> 0xC0000 only; rows_done=1.
